// File: rtl/jtpopeye_objdma.sv
// Object-table DMA: on a frame trigger, takes the CPU bus and copies BANKS x 2^AW words
// into banked (optionally ping-pong) object RAM; the display reads all banks as one word.
module jtpopeye_objdma #(
    parameter int unsigned AW     = 8,
    parameter int unsigned BANKS  = 4,
    parameter int unsigned DW     = 8,
    parameter int unsigned LW     = 5,
    parameter int unsigned RDLAT  = 1,
    parameter int unsigned DOUBLE = 1,
    localparam int unsigned BW    = (BANKS > 1) ? $clog2(BANKS) : 0,
    localparam int unsigned SW    = AW + BW,
    localparam int unsigned OW    = DW * (BANKS - 1) + LW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          VB,
    input  logic          auto_en,
    input  logic          start,
    input  logic          busak_n,
    input  logic [DW-1:0] din,
    output logic          busrq_n,
    output logic [SW-1:0] src_addr,
    output logic          src_cs,
    output logic          busy,
    output logic          done,
    output logic          miss,
    output logic          page,
    input  logic [AW-1:0] rd_addr,
    output logic [OW-1:0] dout
);

    localparam int unsigned CW    = SW + 1;
    localparam int unsigned PW    = (DOUBLE != 0) ? 1 : 0;
    localparam int unsigned DEPTH = 1 << (AW + PW);

    typedef enum logic [2:0] {IDLE, REQ, XFER, DRAIN, REL} state_t;

    state_t           state;
    logic [CW-1:0]    rc;
    logic [CW-1:0]    wc;
    logic [RDLAT-1:0] vld;
    logic             vb_d;

    logic             trig;
    logic             adv;
    logic             take;
    logic             moving;
    logic             wr_en;
    logic [CW-1:0]    rc_nx;
    logic [SW-1:0]    wsel;
    logic [AW+PW-1:0] wr_idx;
    logic [AW+PW-1:0] rd_idx;

    // A read is consumed only on an enabled cycle while the bus is granted and src_cs is up
    assign trig   = auto_en ? (VB & ~vb_d) : start;
    assign adv    = cen & ~busak_n;
    assign take   = adv & src_cs;
    assign moving = (state == XFER) || (state == DRAIN);
    assign rc_nx  = rc + CW'(take);
    assign wr_en  = adv & moving & vld[RDLAT-1];
    assign wsel   = wc[SW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busrq_n  <= 1'b1;
            src_addr <= '0;
            src_cs   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            miss     <= 1'b0;
            page     <= 1'b0;
            rc       <= '0;
            wc       <= '0;
            vld      <= '0;
            vb_d     <= 1'b0;
        end else if (cen) begin
            vb_d <= VB;
            done <= 1'b0;
            if (trig && state != IDLE) miss <= 1'b1;
            // Read-latency tracker and write counter freeze whenever the bus is lost
            if (adv && moving) begin
                vld <= RDLAT'({vld, take});
                if (vld[RDLAT-1]) wc <= wc + CW'(1);
            end
            case (state)
                IDLE: if (trig) begin
                    state   <= REQ;
                    busrq_n <= 1'b0;
                    busy    <= 1'b1;
                    miss    <= 1'b0;
                    rc      <= '0;
                    wc      <= '0;
                    vld     <= '0;
                end
                REQ: if (!busak_n) begin
                    state    <= XFER;
                    src_cs   <= 1'b1;
                    src_addr <= '0;
                end
                XFER: begin
                    rc <= rc_nx;
                    if (rc_nx[CW-1]) begin
                        state  <= DRAIN;
                        src_cs <= 1'b0;
                    end else begin
                        src_cs   <= ~busak_n;
                        src_addr <= rc_nx[SW-1:0];
                    end
                end
                DRAIN: if (wc[CW-1]) begin
                    state   <= REL;
                    busrq_n <= 1'b1;
                    done    <= 1'b1;
                    if (DOUBLE != 0) page <= ~page;
                end
                REL: if (busak_n) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // DMA writes the back page while the display reads the front page
    if (DOUBLE != 0) begin : g_pingpong
        assign wr_idx = {~page, wc[AW-1:0]};
        assign rd_idx = {page, rd_addr};
    end else begin : g_single
        assign wr_idx = wc[AW-1:0];
        assign rd_idx = rd_addr;
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        localparam int unsigned BWD = (b == BANKS - 1) ? LW : DW;
        logic [BWD-1:0] mem [DEPTH];
        logic [BWD-1:0] q;

        always_ff @(posedge clk) begin
            if (wr_en && ((wsel >> AW) == SW'(b))) mem[wr_idx] <= din[BWD-1:0];
            if (cen) q <= mem[rd_idx];
        end

        assign dout[b*DW +: BWD] = q;
    end

endmodule

// File: tb/tb_jtpopeye_objdma.sv
// Bench for jtpopeye_objdma: random cen, bus stalls and source data; reads, done pulses
// and display readback are scoreboarded against an array model of the copied table.
`timescale 1ns/1ps
module tb_jtpopeye_objdma;

    localparam int unsigned AW     = 8;
    localparam int unsigned BANKS  = 4;
    localparam int unsigned DW     = 8;
    localparam int unsigned LW     = 5;
    localparam int unsigned RDLAT  = 3;
    localparam int unsigned DOUBLE = 1;
    localparam int unsigned SW     = AW + 2;
    localparam int unsigned OW     = DW * (BANKS - 1) + LW;
    localparam int unsigned WORDS  = 1 << AW;
    localparam int unsigned TOTAL  = BANKS * WORDS;
    localparam int unsigned LIMIT  = 20000;

    logic          clk = 1'b0;
    logic          rst_n, cen, vb, auto_en, start, busak_n;
    logic [DW-1:0] din;
    logic          busrq_n;
    logic [SW-1:0] src_addr;
    logic          src_cs, busy, done, miss, page;
    logic [AW-1:0] rd_addr;
    logic [OW-1:0] dout;

    jtpopeye_objdma #(
        .AW(AW), .BANKS(BANKS), .DW(DW), .LW(LW), .RDLAT(RDLAT), .DOUBLE(DOUBLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .VB(vb), .auto_en(auto_en), .start(start),
        .busak_n(busak_n), .din(din), .busrq_n(busrq_n), .src_addr(src_addr),
        .src_cs(src_cs), .busy(busy), .done(done), .miss(miss), .page(page),
        .rd_addr(rd_addr), .dout(dout)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_fail = 0;
    int unsigned   src_mem [TOTAL];
    logic [DW-1:0] model [2][BANKS][WORDS];
    bit            known [2];
    int unsigned   addr_q [$];
    int unsigned   done_q [$];
    logic [OW-1:0] rd_q [$];
    int            n_taken = 0;
    int            stall_cnt = 0;
    int            force_stall = 0;
    bit            want_stall = 0;
    bit            rd_arm = 0;
    bit            rd_due = 0;
    bit            lost = 0;
    bit            page_m = 0;
    bit            arm_back = 0;
    logic [DW-1:0] pipe [RDLAT];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: %s", name, why);
    endtask

    // Bus owner and source memory: grant follows request one cen later, with random losses;
    // the memory returns mem[addr] RDLAT granted cen ticks after an address is consumed.
    initial begin
        logic c, b;
        logic [SW-1:0] a;
        cen = 1'b0;
        busak_n = 1'b1;
        din = '0;
        for (int i = 0; i < RDLAT; i++) pipe[i] = '0;
        forever begin
            @(negedge clk);
            c = cen;
            b = busak_n;
            a = src_addr;
            @(posedge clk);
            #1;
            if (c && !b) begin
                for (int i = RDLAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
                pipe[0] = DW'(src_mem[a]);
                din = pipe[RDLAT-1];
            end
            if (c) begin
                if (force_stall > 0) begin
                    stall_cnt = force_stall;
                    force_stall = 0;
                end else if (stall_cnt == 0 && !busrq_n && $urandom_range(0, 99) == 0) begin
                    stall_cnt = $urandom_range(1, 6);
                end
                if (stall_cnt > 0) begin
                    busak_n = 1'b1;
                    stall_cnt--;
                end else begin
                    busak_n = busrq_n;
                end
            end
            cen = ($urandom_range(0, 3) != 0);
        end
    end

    always @(posedge clk) rd_due <= cen && rd_arm;

    // Monitor: pops expectations whenever the DUT consumes a read, pulses done or returns read data
    always @(negedge clk) begin
        if (rst_n) begin
            if (lost && busy) chk("src_cs_during_bus_loss", src_cs, 0);
            if (cen && !busak_n && src_cs) begin
                if (addr_q.size() == 0) fail_now("extra_read", $sformatf("unexpected read at %0d", src_addr));
                else chk("src_addr", src_addr, addr_q.pop_front());
                n_taken++;
                if (want_stall && src_addr == SW'(300)) begin
                    force_stall = 10;
                    want_stall = 0;
                end
            end
            if (cen && done) begin
                if (done_q.size() == 0) fail_now("extra_done", "done pulsed with no transfer pending");
                else begin
                    chk("done_page", page, done_q.pop_front());
                    chk("done_busrq_n", busrq_n, 1);
                    chk("reads_left_at_done", addr_q.size(), 0);
                end
            end
            if (rd_due) begin
                if (rd_q.size() == 0) fail_now("extra_dout", "read data with no read pending");
                else chk("dout", dout, rd_q.pop_front());
            end
            if (cen) lost = busak_n;
        end else begin
            lost = 0;
        end
    end

    task automatic wait_cen();
        @(posedge clk);
        while (!cen) @(posedge clk);
        #2;
    endtask

    task automatic vb_pulse();
        vb = 1'b1;
        repeat (3) wait_cen();
        vb = 1'b0;
        repeat (3) wait_cen();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        wait_cen();
        start = 1'b0;
    endtask

    task automatic arm();
        for (int i = 0; i < TOTAL; i++) src_mem[i] = $urandom;
        addr_q.delete();
        for (int i = 0; i < TOTAL; i++) addr_q.push_back(i);
        arm_back = DOUBLE != 0 ? ~page_m : 1'b0;
        done_q.push_back(arm_back);
        n_taken = 0;
    endtask

    task automatic commit();
        logic [DW-1:0] v;
        for (int k = 0; k < BANKS; k++)
            for (int i = 0; i < WORDS; i++) begin
                v = DW'(src_mem[k*WORDS + i]);
                if (k == BANKS - 1) v = v & DW'((1 << LW) - 1);
                model[arm_back][k][i] = v;
            end
        known[arm_back] = 1;
        page_m = arm_back;
    endtask

    task automatic readback(input bit pg);
        logic [OW-1:0] e;
        if (!known[pg]) return;
        for (int i = 0; i < WORDS; i++) begin
            e = '0;
            for (int k = 0; k < BANKS; k++) e = e | (OW'(model[pg][k][i]) << (k * DW));
            rd_addr = AW'(i);
            rd_q.push_back(e);
            rd_arm = 1;
            wait_cen();
        end
        rd_arm = 0;
    endtask

    task automatic wait_taken(input int n);
        int cnt = 0;
        while (n_taken < n && cnt < LIMIT) begin
            @(negedge clk);
            cnt++;
        end
        if (n_taken < n) fail_now("timeout_reads", $sformatf("only %0d reads, required %0d", n_taken, n));
    endtask

    task automatic wait_idle(input string what);
        int cnt = 0;
        while (busy && cnt < LIMIT) begin
            @(negedge clk);
            cnt++;
        end
        if (busy) fail_now({"timeout_", what}, "busy still 1, required 0");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        vb = 1'b0;
        auto_en = 1'b1;
        start = 1'b0;
        rd_addr = '0;
        known[0] = 0;
        known[1] = 0;
        repeat (4) @(posedge clk);
        #2;
        chk("rst_busrq_n", busrq_n, 1);
        chk("rst_src_cs", src_cs, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_miss", miss, 0);
        chk("rst_page", page, 0);
        chk("rst_src_addr", src_addr, 0);
        rst_n = 1'b1;

        // Reset in the middle of a transfer, then restart from address 0
        arm();
        vb_pulse();
        chk("t1_busy", busy, 1);
        chk("t1_busrq_n", busrq_n, 0);
        wait_taken(500);
        rst_n = 1'b0;
        #1;
        chk("midrst_busrq_n", busrq_n, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_src_cs", src_cs, 0);
        chk("midrst_page", page, 0);
        addr_q.delete();
        done_q.delete();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Full VB-triggered transfer with a long bus loss and a missed VB edge
        arm();
        want_stall = 1;
        vb_pulse();
        wait_taken(200);
        vb_pulse();
        chk("t2_miss_set", miss, 1);
        wait_idle("t2");
        commit();
        chk("t2_miss_sticky", miss, 1);
        chk("t2_busrq_n", busrq_n, 1);
        chk("t2_page", page, page_m);
        readback(page_m);

        // Start-triggered transfers; front page must stay stable while the back page fills
        auto_en = 1'b0;
        vb_pulse();
        chk("vb_ignored_busy", busy, 0);
        arm();
        pulse_start();
        chk("t3_busy", busy, 1);
        chk("t3_miss_cleared", miss, 0);
        fork
            readback(page_m);
            begin
                wait_taken(200);
                pulse_start();
                chk("t3_miss_set", miss, 1);
            end
        join
        wait_idle("t3");
        commit();
        chk("t3_page", page, page_m);
        readback(page_m);

        arm();
        pulse_start();
        chk("t4_miss_cleared", miss, 0);
        wait_idle("t4");
        commit();
        readback(page_m);
        repeat (4) @(negedge clk);
        chk("t4_page", page, page_m);
        chk("t4_busy", busy, 0);
        chk("rd_left", rd_q.size(), 0);
        chk("done_left", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
